// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants and types for the IF/ID pipeline segment
package cpu_pkg;

  localparam logic [31:0] NOP_INST = 32'h0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } seg_state_t;

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one pipeline entry: valid bit plus PC/instruction payload
// Load wins over clear so a same-edge consume-and-refill keeps the entry valid.
module pipe_slot #(
  parameter int              PC_W     = 32,
  parameter int              INST_W   = 32,
  parameter logic [INST_W-1:0] RST_INST = '0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic              clear,
  input  logic [PC_W-1:0]   d_pc,
  input  logic [INST_W-1:0] d_inst,
  output logic              valid,
  output logic [PC_W-1:0]   pc,
  output logic [INST_W-1:0] inst
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid <= 1'b0;
      pc    <= '0;
      inst  <= RST_INST;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= d_pc;
      inst  <= d_inst;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/if_id_pipe_seg.sv
// rtl/if_id_pipe_seg.sv - IF/ID pipeline segment, plain register or two-entry skid buffer
// The payload is never cleared, so out_pc keeps the last head PC while out_valid is low.
module if_id_pipe_seg #(
  parameter int                PC_W     = 32,
  parameter int                INST_W   = 32,
  parameter int                SKID     = 1,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(cpu_pkg::NOP_INST)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst
);

  logic              head_load;
  logic              head_clear;
  logic              head_valid;
  logic [PC_W-1:0]   head_d_pc;
  logic [PC_W-1:0]   head_pc;
  logic [INST_W-1:0] head_d_inst;
  logic [INST_W-1:0] head_inst;
  logic              xin;
  logic              xout;

  assign xin  = in_valid && in_ready;
  assign xout = head_valid && out_ready;

  pipe_slot #(.PC_W(PC_W), .INST_W(INST_W), .RST_INST(NOP_INST)) u_head (
    .clk    (clk),
    .resetn (resetn),
    .load   (head_load),
    .clear  (head_clear),
    .d_pc   (head_d_pc),
    .d_inst (head_d_inst),
    .valid  (head_valid),
    .pc     (head_pc),
    .inst   (head_inst)
  );

  assign out_valid = head_valid;
  assign out_pc    = head_pc;
  assign out_inst  = head_valid ? head_inst : NOP_INST;

  generate
    if (SKID == 0) begin : g_reg
      assign in_ready    = resetn && (!head_valid || out_ready);
      assign head_load   = xin && !flush;
      assign head_clear  = flush || xout;
      assign head_d_pc   = in_pc;
      assign head_d_inst = in_inst;
    end else begin : g_skid
      cpu_pkg::seg_state_t state;
      cpu_pkg::seg_state_t state_nxt;
      logic              ready_q;
      logic              skid_load;
      logic              skid_clear;
      logic              skid_valid;
      logic [PC_W-1:0]   skid_pc;
      logic [INST_W-1:0] skid_inst;

      pipe_slot #(.PC_W(PC_W), .INST_W(INST_W), .RST_INST(NOP_INST)) u_skid (
        .clk    (clk),
        .resetn (resetn),
        .load   (skid_load),
        .clear  (skid_clear),
        .d_pc   (in_pc),
        .d_inst (in_inst),
        .valid  (skid_valid),
        .pc     (skid_pc),
        .inst   (skid_inst)
      );

      // ready is registered from the next state, so out_ready never reaches in_ready
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          state   <= cpu_pkg::EMPTY;
          ready_q <= 1'b1;
        end else begin
          state   <= state_nxt;
          ready_q <= (state_nxt != cpu_pkg::FULL);
        end
      end

      always_comb begin
        state_nxt = state;
        if (flush) begin
          state_nxt = cpu_pkg::EMPTY;
        end else begin
          case (state)
            cpu_pkg::EMPTY: if (xin) state_nxt = cpu_pkg::BUSY;
            cpu_pkg::BUSY: begin
              if (xin && !xout)      state_nxt = cpu_pkg::FULL;
              else if (!xin && xout) state_nxt = cpu_pkg::EMPTY;
            end
            cpu_pkg::FULL:  if (xout) state_nxt = cpu_pkg::BUSY;
            default:        state_nxt = cpu_pkg::EMPTY;
          endcase
        end
      end

      always_comb begin
        head_load   = 1'b0;
        head_clear  = flush;
        skid_load   = 1'b0;
        skid_clear  = flush;
        head_d_pc   = in_pc;
        head_d_inst = in_inst;
        if (!flush) begin
          case (state)
            cpu_pkg::EMPTY: head_load = xin;
            cpu_pkg::BUSY: begin
              if (xin) begin
                head_load = xout;
                skid_load = !xout;
              end else begin
                head_clear = xout;
              end
            end
            cpu_pkg::FULL: begin
              if (xout && skid_valid) begin
                head_load   = 1'b1;
                head_d_pc   = skid_pc;
                head_d_inst = skid_inst;
                skid_clear  = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end

      assign in_ready = ready_q && resetn;
    end
  endgenerate

endmodule

// File: tb/tb_if_id_pipe_seg.sv
// tb/tb_if_id_pipe_seg.sv - scoreboard bench for both SKID variants of if_id_pipe_seg
module tb_if_id_pipe_seg;

  localparam logic [31:0] P0 = 32'h1c00_0000;

  logic        clk;
  logic        resetn;
  logic        flush_a     [2];
  logic        in_valid_a  [2];
  logic        in_ready_a  [2];
  logic [31:0] in_pc_a     [2];
  logic [31:0] in_inst_a   [2];
  logic        out_valid_a [2];
  logic        out_ready_a [2];
  logic [31:0] out_pc_a    [2];
  logic [31:0] out_inst_a  [2];

  int nchk = 0;
  int nerr = 0;
  int nout [2];

  // reference FIFO per instance: capacity 1 (SKID=0) or 2 (SKID=1)
  logic [31:0] m_pc   [2][4];
  logic [31:0] m_inst [2][4];
  int          m_head [2];
  int          m_cnt  [2];
  logic [31:0] m_last [2];

  if_id_pipe_seg #(.PC_W(32), .INST_W(32), .SKID(0), .NOP_INST(32'h0)) u_seg0 (
    .clk(clk), .resetn(resetn), .flush(flush_a[0]),
    .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]),
    .in_pc(in_pc_a[0]), .in_inst(in_inst_a[0]),
    .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]),
    .out_pc(out_pc_a[0]), .out_inst(out_inst_a[0])
  );

  if_id_pipe_seg #(.PC_W(32), .INST_W(32), .SKID(1), .NOP_INST(32'h0)) u_seg1 (
    .clk(clk), .resetn(resetn), .flush(flush_a[1]),
    .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]),
    .in_pc(in_pc_a[1]), .in_inst(in_inst_a[1]),
    .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]),
    .out_pc(out_pc_a[1]), .out_inst(out_inst_a[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s skid%0d: got %h expected %h at %0t", nm, k, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'ha5a5_0013;
  endfunction

  task automatic drive_all(input logic fl, input logic iv, input logic [31:0] pc, input logic ordy);
    for (int k = 0; k < 2; k++) begin
      flush_a[k]     = fl;
      in_valid_a[k]  = iv;
      in_pc_a[k]     = pc;
      in_inst_a[k]   = inst_of(pc);
      out_ready_a[k] = ordy;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // monitor: compare visible state with the model, then apply this cycle's transfers
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!resetn) begin
        chk("rst_out_valid", k, {31'd0, out_valid_a[k]}, 32'd0);
        chk("rst_in_ready", k, {31'd0, in_ready_a[k]}, 32'd0);
        chk("rst_out_pc", k, out_pc_a[k], 32'd0);
        m_cnt[k]  = 0;
        m_head[k] = 0;
        m_last[k] = 32'd0;
      end else begin
        logic exp_rdy;
        exp_rdy = (k == 0) ? (m_cnt[k] == 0 || out_ready_a[k]) : (m_cnt[k] < 2);
        chk("out_valid", k, {31'd0, out_valid_a[k]}, {31'd0, m_cnt[k] != 0});
        chk("in_ready", k, {31'd0, in_ready_a[k]}, {31'd0, exp_rdy});
        if (m_cnt[k] != 0) begin
          chk("out_pc", k, out_pc_a[k], m_pc[k][m_head[k]]);
          chk("out_inst", k, out_inst_a[k], m_inst[k][m_head[k]]);
        end else begin
          chk("idle_pc", k, out_pc_a[k], m_last[k]);
          chk("idle_inst", k, out_inst_a[k], 32'h0);
        end
        if (flush_a[k]) begin
          m_cnt[k] = 0;
        end else begin
          if (out_valid_a[k] && out_ready_a[k] && m_cnt[k] != 0) begin
            m_head[k] = (m_head[k] + 1) % 4;
            m_cnt[k]--;
            nout[k]++;
          end
          if (in_valid_a[k] && in_ready_a[k]) begin
            if (m_cnt[k] == 4) begin
              chk("model_overflow", k, 32'd4, 32'd3);
            end else begin
              m_pc[k][(m_head[k] + m_cnt[k]) % 4]   = in_pc_a[k];
              m_inst[k][(m_head[k] + m_cnt[k]) % 4] = in_inst_a[k];
              m_cnt[k]++;
            end
          end
        end
        if (m_cnt[k] != 0) m_last[k] = m_pc[k][m_head[k]];
      end
    end
  end

  initial begin
    int cyc;
    nout[0] = 0;
    nout[1] = 0;
    resetn = 1'b0;
    drive_all(1'b0, 1'b0, 32'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("init_out_valid", k, {31'd0, out_valid_a[k]}, 32'd0);
      chk("init_in_ready", k, {31'd0, in_ready_a[k]}, 32'd0);
      chk("init_out_inst", k, out_inst_a[k], 32'h0);
    end
    resetn = 1'b1;
    step();
    for (int k = 0; k < 2; k++) chk("release_in_ready", k, {31'd0, in_ready_a[k]}, 32'd1);

    // back-to-back streaming, one-cycle latency, no bubbles
    for (int i = 0; i < 3; i++) begin
      drive_all(1'b0, 1'b1, P0 + 32'(4 * i), 1'b1);
      step();
      for (int k = 0; k < 2; k++) begin
        chk("stream_valid", k, {31'd0, out_valid_a[k]}, 32'd1);
        chk("stream_pc", k, out_pc_a[k], P0 + 32'(4 * i));
      end
    end
    drive_all(1'b0, 1'b0, 32'd0, 1'b1);
    step();

    // stall with in_valid held high
    drive_all(1'b0, 1'b1, P0, 1'b0);
    step();
    drive_all(1'b0, 1'b1, P0 + 32'd4, 1'b0);
    step();
    for (int k = 0; k < 2; k++) begin
      chk("stall_in_ready", k, {31'd0, in_ready_a[k]}, 32'd0);
      chk("stall_pc", k, out_pc_a[k], P0);
    end
    drive_all(1'b0, 1'b1, P0 + 32'd8, 1'b0);
    step();
    chk("stall_hold_pc", 1, out_pc_a[1], P0);
    drive_all(1'b0, 1'b0, 32'd0, 1'b1);
    step();
    chk("stall_second_pc", 1, out_pc_a[1], P0 + 32'd4);
    step();

    // flush while FULL with a fetch in the same cycle
    drive_all(1'b0, 1'b1, 32'h2000_0000, 1'b0);
    step();
    drive_all(1'b0, 1'b1, 32'h2000_0004, 1'b0);
    step();
    chk("full_in_ready", 1, {31'd0, in_ready_a[1]}, 32'd0);
    drive_all(1'b1, 1'b1, 32'h2000_0008, 1'b0);
    step();
    drive_all(1'b0, 1'b0, 32'd0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      chk("flush_valid", k, {31'd0, out_valid_a[k]}, 32'd0);
      chk("flush_inst", k, out_inst_a[k], 32'h0);
      chk("flush_in_ready", k, {31'd0, in_ready_a[k]}, 32'd1);
    end
    step();
    step();

    // simultaneous in/out while holding one entry
    drive_all(1'b0, 1'b1, 32'h3000_0000, 1'b0);
    step();
    drive_all(1'b0, 1'b1, 32'h3000_0010, 1'b1);
    step();
    for (int k = 0; k < 2; k++) begin
      chk("busy_swap_pc", k, out_pc_a[k], 32'h3000_0010);
      chk("busy_swap_ready", k, {31'd0, in_ready_a[k]}, 32'd1);
    end
    drive_all(1'b0, 1'b0, 32'd0, 1'b1);
    step();

    // asynchronous reset in the middle of a stalled stream
    drive_all(1'b0, 1'b1, 32'h4000_0000, 1'b0);
    step();
    drive_all(1'b0, 1'b1, 32'h4000_0004, 1'b0);
    step();
    #2 resetn = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("midrst_valid", k, {31'd0, out_valid_a[k]}, 32'd0);
      chk("midrst_pc", k, out_pc_a[k], 32'd0);
      chk("midrst_inst", k, out_inst_a[k], 32'h0);
    end
    drive_all(1'b0, 1'b0, 32'd0, 1'b0);
    step();
    resetn = 1'b1;
    step();
    for (int k = 0; k < 2; k++) chk("midrst_release_ready", k, {31'd0, in_ready_a[k]}, 32'd1);

    // random valid/ready/flush traffic
    nout[0] = 0;
    nout[1] = 0;
    cyc = 0;
    while ((nout[0] < 10000 || nout[1] < 10000) && cyc < 80000) begin
      for (int k = 0; k < 2; k++) begin
        logic [31:0] pc;
        pc             = $urandom & 32'hffff_fffc;
        flush_a[k]     = ($urandom_range(0, 63) == 0);
        in_valid_a[k]  = ($urandom_range(0, 9) < 7);
        in_pc_a[k]     = pc;
        in_inst_a[k]   = $urandom;
        out_ready_a[k] = ($urandom_range(0, 9) < 6);
      end
      step();
      cyc++;
    end
    for (int k = 0; k < 2; k++)
      if (nout[k] < 10000) chk("random_timeout", k, 32'(nout[k]), 32'd10000);
    drive_all(1'b0, 1'b0, 32'd0, 1'b1);
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
